block_averager: RTL and testbench

//   Averages a block of N = len+1 (1..16) unsigned 8-bit samples. It accepts samples over a

---
 rtl/block_averager.sv | 131 +++++++++++++
 tb/tb_block_averager.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_averager.sv
// Block mean of N=len+1 unsigned samples via LUT reciprocal and 8-cycle shift-add multiply.
// Result valid 1 edge (N=1) or 10 edges after the last sample; held in DONE until out_ready.
module block_averager #(
  parameter int DW = 8,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [NW-1:0] lut_addr,
  input  logic [15:0]   lut_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] avg,
  output logic          busy
);

  localparam int SW = DW + NW;
  localparam int PW = SW + DW;
  localparam int BW = $clog2(DW);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] len_q, len_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] recip_q, recip_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] avg_q, avg_d;
  logic [PW:0]   rnd;
  logic          lut_unused;

  // Upper LUT byte carries nothing this block needs.
  assign lut_unused = ^lut_data[15:DW];

  assign rnd = {1'b0, prod_q} + (PW+1)'(1 << (DW-1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    recip_d = recip_q;
    prod_d  = prod_q;
    bit_d   = bit_q;
    avg_d   = avg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          sum_d = sum_q + SW'(in_data);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q) state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        recip_d = lut_data[DW-1:0];
        prod_d  = '0;
        bit_d   = '0;
        // A single sample is its own mean; LUT entry 0 cannot represent 1.0.
        if (len_q == '0) begin
          avg_d   = sum_q[DW-1:0];
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (recip_q[bit_q]) prod_d = prod_q + (PW'(sum_q) << bit_q);
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DW-1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (|rnd[PW:2*DW]) avg_d = '1;
        else               avg_d = rnd[2*DW-1:DW];
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      recip_q <= '0;
      prod_q  <= '0;
      bit_q   <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      recip_q <= recip_d;
      prod_q  <= prod_d;
      bit_q   <= bit_d;
      avg_q   <= avg_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign lut_addr  = len_q;
  assign avg       = avg_q;

endmodule

// File: tb/tb_block_averager.sv
// Randomized self-checking bench for block_averager with an arithmetic mean-by-reciprocal model.
module tb_block_averager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  lut_addr;
    logic [15:0] lut_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  avg;
    logic        busy;
    logic [7:0]  junk_hi;

    int errors = 0;
    int checks = 0;
    int smp[16];

    always #5 clk = ~clk;

    // Reciprocal table: floor(256/N) for N>=2, entry 0 is 0xFF.
    function automatic logic [7:0] lut_val(input logic [3:0] k);
        if (k == 4'd0) return 8'hFF;
        return 8'(256 / (int'(k) + 1));
    endfunction

    assign lut_data = {junk_hi, lut_val(lut_addr)};

    block_averager dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .out_valid(out_valid), .out_ready(out_ready), .avg(avg), .busy(busy)
    );

    // Runs one block from IDLE through the output handshake; gap<0 means random gaps.
    task automatic run_block(input int n, input int gap, input int stall, input bit noise,
                             input string tag);
        int sum, expv, explat, lat, g;
        sum = 0;
        for (int i = 0; i < n; i++) sum += smp[i];
        if (n == 1) expv = sum;
        else begin
            expv = (sum * (256 / n) + 128) / 256;
            if (expv > 255) expv = 255;
        end
        explat = (n == 1) ? 1 : 10;

        start = 1'b1; len = 4'(n - 1); junk_hi = 8'($urandom);
        in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; len = 4'($urandom);
        checks++;
        if (lut_addr !== 4'(n - 1)) begin
            errors++;
            $display("FAIL %s lut_addr: got %0d want %0d", tag, lut_addr, n - 1);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s enter_accum: in_ready=%b busy=%b want 1 1", tag, in_ready, busy);
        end

        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                start = noise;
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s gap_in_ready: got %b want 1", tag, in_ready);
                end
            end
            in_valid = 1'b1; in_data = 8'(smp[i]);
            @(negedge clk);
        end
        in_valid = 1'b0;

        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (noise) begin
                start = 1'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (lat != explat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", tag, lat, explat);
        end
        checks++;
        if (avg !== 8'(expv)) begin
            errors++;
            $display("FAIL %s avg: got %0d want %0d", tag, avg, expv);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: busy=%b in_ready=%b want 1 0", tag, busy, in_ready);
        end

        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || avg !== 8'(expv) || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s stall: out_valid=%b avg=%0d busy=%b want 1 %0d 1",
                         tag, out_valid, avg, busy, expv);
            end
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || avg !== 8'(expv)) begin
            errors++;
            $display("FAIL %s handshake: out_valid=%b busy=%b avg=%0d want 0 0 %0d",
                     tag, out_valid, busy, avg, expv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = 4'd7; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; junk_hi = 8'h5A;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || avg !== 8'd0 ||
            lut_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b avg=%0d lut_addr=%0d want all 0",
                     in_ready, out_valid, busy, avg, lut_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic();
        smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 40;
        run_block(4, 0, 0, 1'b0, "basic");
        smp[0] = 255; smp[1] = 255; smp[2] = 255;
        run_block(3, 0, 0, 1'b0, "n3_max");
    endtask

    task automatic test_single();
        smp[0] = 200;
        run_block(1, 0, 0, 1'b0, "single");
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) smp[i] = 255;
        run_block(16, 0, 0, 1'b0, "full");
    endtask

    task automatic test_gaps();
        smp[0] = 3; smp[1] = 3; smp[2] = 3;
        run_block(3, 2, 0, 1'b1, "gaps");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) smp[i] = int'($urandom_range(0, 255));
        run_block(5, 0, 5, 1'b0, "stall");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'd50;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || avg !== 8'd0 ||
            lut_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b avg=%0d lut_addr=%0d want all 0",
                     in_ready, out_valid, busy, avg, lut_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        smp[0] = 8; smp[1] = 9;
        run_block(2, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int n;
        for (int b = 0; b < 25; b++) begin
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) smp[i] = int'($urandom_range(0, 255));
            if (b % 5 == 0)
                for (int i = 0; i < n; i++) smp[i] = int'($urandom_range(240, 255));
            run_block(n, -1, int'($urandom_range(0, 3)), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_full();
        test_gaps();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
